// File: rtl/stopwatch_core_if.sv
// Key-pulse inputs and BCD display outputs of the stopwatch core.
// master drives the keys and observes the display; slave is the core itself.
interface stopwatch_core_if;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        wrap;

    modport master (
        output start_stop, clear, lap,
        input  disp_bcd, running, lap_active, wrap
    );

    modport slave (
        input  start_stop, clear, lap,
        output disp_bcd, running, lap_active, wrap
    );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS.cc stopwatch: centisecond prescaler, BCD cascade, IDLE/RUN/PAUSE/LAP control.
// Outputs registered one edge after the key pulse; no backpressure, pulses are never queued.
module stopwatch_core #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    stopwatch_core_if.slave  sw
);

    localparam int unsigned    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [23:0]    TIME_MAX   = 24'h595999;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   time_q, time_d;
    logic [23:0]   lap_q, lap_d;
    logic          running_q, running_d;
    logic          lap_active_q, lap_active_d;
    logic          wrap_q, wrap_d;

    logic          counting;
    logic          tick;

    // Digit order, low to high: cs_o, cs_t, sec_o, sec_t, min_o, min_t.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  lim;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[i*4 +: 4] >= lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign counting = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick     = counting && (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        time_d  = time_q;
        lap_d   = lap_q;
        wrap_d  = 1'b0;

        if (sw.clear) begin
            state_d = S_IDLE;
            presc_d = '0;
            time_d  = '0;
            lap_d   = '0;
        end else begin
            if (counting) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
            if (tick) begin
                time_d = bcd_inc(time_q);
                wrap_d = (time_q == TIME_MAX);
            end

            // start_stop outranks lap; a dropped lap pulse is simply lost.
            unique case (state_q)
                S_IDLE: begin
                    if (sw.start_stop) state_d = S_RUN;
                end
                S_RUN: begin
                    if (sw.start_stop) begin
                        state_d = S_PAUSE;
                    end else if (sw.lap) begin
                        state_d = S_LAP;
                        lap_d   = time_q;
                    end
                end
                S_LAP: begin
                    if (sw.start_stop)  state_d = S_PAUSE;
                    else if (sw.lap)    state_d = S_RUN;
                end
                S_PAUSE: begin
                    if (sw.start_stop) state_d = S_RUN;
                end
            endcase
        end

        running_d    = (state_d == S_RUN) || (state_d == S_LAP);
        lap_active_d = (state_d == S_LAP);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            time_q       <= '0;
            lap_q        <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            time_q       <= time_d;
            lap_q        <= lap_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            wrap_q       <= wrap_d;
        end
    end

    assign sw.disp_bcd   = lap_active_q ? lap_q : time_q;
    assign sw.running    = running_q;
    assign sw.lap_active = lap_active_q;
    assign sw.wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: a TICK_DIV=4 instance for control/counting scenarios and a
// TICK_DIV=2 instance whose time register is preloaded to reach the rollover quickly.
module tb_stopwatch_core;

    typedef struct packed {
        logic [23:0] disp;
        logic        run;
        logic        lapa;
        logic        wrap;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];

    always #10 clk = ~clk;

    stopwatch_core_if sw4();
    stopwatch_core_if sw2();

    stopwatch_core #(.TICK_DIV(4)) dut4 (.CLOCK_50(clk), .reset(rst), .sw(sw4.slave));
    stopwatch_core #(.TICK_DIV(2)) dut2 (.CLOCK_50(clk), .reset(rst), .sw(sw2.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t mk(input logic [23:0] d, input logic r, input logic l, input logic w);
        obs_t o;
        o.disp = d;
        o.run  = r;
        o.lapa = l;
        o.wrap = w;
        return o;
    endfunction

    function automatic obs_t obs4();
        return mk(sw4.disp_bcd, sw4.running, sw4.lap_active, sw4.wrap);
    endfunction

    function automatic obs_t obs2();
        return mk(sw2.disp_bcd, sw2.running, sw2.lap_active, sw2.wrap);
    endfunction

    // Independent reference: total centiseconds -> packed BCD MM:SS.cc.
    function automatic logic [23:0] bcd_of(input int n);
        int cs, s, m;
        cs = n % 100;
        s  = (n / 100) % 60;
        m  = (n / 6000) % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic test_reset();
        obs_t e, o;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) exp_q.push_back(mk(24'h0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 20; i++) begin
            step();
            e = exp_q.pop_front(); o = obs4(); total++;
            if (o !== e) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, o, e); end
        end
        exp_q.push_back(mk(24'h0, 1'b0, 1'b0, 1'b0));
        e = exp_q.pop_front(); o = obs2(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_idle_div2 got=%h want=%h", o, e); end
    endtask

    task automatic test_count();
        obs_t e, o;
        sw4.start_stop = 1'b1;
        exp_q.push_back(mk(24'h0, 1'b1, 1'b0, 1'b0));
        step();
        sw4.start_stop = 1'b0;
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL count_start got=%h want=%h", o, e); end
        for (int c = 1; c <= 400; c++) exp_q.push_back(mk(bcd_of(c / 4), 1'b1, 1'b0, 1'b0));
        for (int c = 1; c <= 400; c++) begin
            step();
            e = exp_q.pop_front(); o = obs4(); total++;
            if (o !== e) begin bad++; $display("FAIL count edge=%0d got=%h want=%h", c, o, e); end
        end
    endtask

    task automatic test_pause();
        obs_t e, o;
        sw4.clear = 1'b1;
        exp_q.push_back(mk(24'h0, 1'b0, 1'b0, 1'b0));
        step();
        sw4.clear = 1'b0;
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL pause_clear got=%h want=%h", o, e); end
        sw4.start_stop = 1'b1;
        step();
        sw4.start_stop = 1'b0;
        step();
        sw4.start_stop = 1'b1;
        exp_q.push_back(mk(24'h0, 1'b0, 1'b0, 1'b0));
        step();
        sw4.start_stop = 1'b0;
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL pause_enter got=%h want=%h", o, e); end
        for (int i = 0; i < 50; i++) exp_q.push_back(mk(24'h0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 50; i++) begin
            step();
            e = exp_q.pop_front(); o = obs4(); total++;
            if (o !== e) begin bad++; $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, o, e); end
        end
        // Prescaler was left at 2 of 4: the tick must land two edges after resume.
        sw4.start_stop = 1'b1;
        exp_q.push_back(mk(24'h0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h000001, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step();
            sw4.start_stop = 1'b0;
            e = exp_q.pop_front(); o = obs4(); total++;
            if (o !== e) begin bad++; $display("FAIL pause_resume cyc=%0d got=%h want=%h", i, o, e); end
        end
    endtask

    task automatic test_lap();
        obs_t e, o;
        sw4.clear = 1'b1;
        step();
        sw4.clear = 1'b0;
        sw4.start_stop = 1'b1;
        step();
        sw4.start_stop = 1'b0;
        for (int c = 1; c <= 495; c++) step();
        exp_q.push_back(mk(24'h000123, 1'b1, 1'b0, 1'b0));
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL lap_preroll got=%h want=%h", o, e); end
        // Edge 496 is also a tick edge: the lap must capture the pre-increment 01.23.
        sw4.lap = 1'b1;
        exp_q.push_back(mk(24'h000123, 1'b1, 1'b1, 1'b0));
        step();
        sw4.lap = 1'b0;
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL lap_enter got=%h want=%h", o, e); end
        for (int c = 497; c <= 536; c++) exp_q.push_back(mk(24'h000123, 1'b1, 1'b1, 1'b0));
        for (int c = 497; c <= 536; c++) begin
            step();
            e = exp_q.pop_front(); o = obs4(); total++;
            if (o !== e) begin bad++; $display("FAIL lap_frozen edge=%0d got=%h want=%h", c, o, e); end
        end
        sw4.lap = 1'b1;
        exp_q.push_back(mk(bcd_of(537 / 4), 1'b1, 1'b0, 1'b0));
        step();
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL lap_exit got=%h want=%h", o, e); end
        sw4.start_stop = 1'b1;
        exp_q.push_back(mk(bcd_of(538 / 4), 1'b0, 1'b0, 1'b0));
        step();
        sw4.start_stop = 1'b0;
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL lap_ss_same_cycle got=%h want=%h", o, e); end
        exp_q.push_back(mk(bcd_of(538 / 4), 1'b0, 1'b0, 1'b0));
        step();
        sw4.lap = 1'b0;
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL lap_in_pause got=%h want=%h", o, e); end
    endtask

    task automatic test_clear();
        obs_t e, o;
        // Paused with prescaler at 2; resume, then clear+start_stop on the tick edge.
        sw4.start_stop = 1'b1;
        exp_q.push_back(mk(bcd_of(134), 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(bcd_of(134), 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            step();
            sw4.start_stop = 1'b0;
            e = exp_q.pop_front(); o = obs4(); total++;
            if (o !== e) begin bad++; $display("FAIL clear_resume cyc=%0d got=%h want=%h", i, o, e); end
        end
        sw4.clear = 1'b1;
        sw4.start_stop = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(24'h0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            step();
            sw4.clear = 1'b0;
            sw4.start_stop = 1'b0;
            e = exp_q.pop_front(); o = obs4(); total++;
            if (o !== e) begin bad++; $display("FAIL clear_on_tick cyc=%0d got=%h want=%h", i, o, e); end
        end
    endtask

    task automatic test_wrap();
        obs_t e, o;
        sw2.start_stop = 1'b1;
        step();
        exp_q.push_back(mk(24'h0, 1'b0, 1'b0, 1'b0));
        step();
        sw2.start_stop = 1'b0;
        e = exp_q.pop_front(); o = obs2(); total++;
        if (o !== e) begin bad++; $display("FAIL wrap_pause got=%h want=%h", o, e); end
        force dut2.time_q = 24'h595999;
        step();
        step();
        release dut2.time_q;
        step();
        sw2.start_stop = 1'b1;
        exp_q.push_back(mk(24'h595999, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h000000, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(24'h000000, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h000001, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            step();
            sw2.start_stop = 1'b0;
            e = exp_q.pop_front(); o = obs2(); total++;
            if (o !== e) begin bad++; $display("FAIL wrap_roll cyc=%0d got=%h want=%h", i, o, e); end
        end
        sw2.start_stop = 1'b1;
        step();
        sw2.start_stop = 1'b0;
        force dut2.time_q = 24'h095999;
        step();
        step();
        release dut2.time_q;
        step();
        sw2.start_stop = 1'b1;
        exp_q.push_back(mk(24'h095999, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h100000, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            step();
            sw2.start_stop = 1'b0;
            e = exp_q.pop_front(); o = obs2(); total++;
            if (o !== e) begin bad++; $display("FAIL wrap_min_carry cyc=%0d got=%h want=%h", i, o, e); end
        end
    endtask

    task automatic test_reset_in_lap();
        obs_t e, o;
        sw4.start_stop = 1'b1;
        step();
        sw4.start_stop = 1'b0;
        for (int c = 1; c <= 5; c++) step();
        sw4.lap = 1'b1;
        exp_q.push_back(mk(bcd_of(6 / 4), 1'b1, 1'b1, 1'b0));
        step();
        sw4.lap = 1'b0;
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL rst_lap_enter got=%h want=%h", o, e); end
        rst = 1'b1;
        sw4.start_stop = 1'b1;
        sw4.lap = 1'b1;
        exp_q.push_back(mk(24'h0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h0, 1'b0, 1'b0, 1'b0));
        step();
        rst = 1'b0;
        sw4.start_stop = 1'b0;
        sw4.lap = 1'b0;
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL rst_in_lap got=%h want=%h", o, e); end
        e = exp_q.pop_front(); o = obs2(); total++;
        if (o !== e) begin bad++; $display("FAIL rst_div2 got=%h want=%h", o, e); end
        exp_q.push_back(mk(24'h0, 1'b0, 1'b0, 1'b0));
        step();
        e = exp_q.pop_front(); o = obs4(); total++;
        if (o !== e) begin bad++; $display("FAIL rst_after got=%h want=%h", o, e); end
    endtask

    initial begin
        sw4.start_stop = 1'b0; sw4.clear = 1'b0; sw4.lap = 1'b0;
        sw2.start_stop = 1'b0; sw2.clear = 1'b0; sw2.lap = 1'b0;
        test_reset();
        test_count();
        test_pause();
        test_lap();
        test_clear();
        test_wrap();
        test_reset_in_lap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping core of the stopwatch that consumes the one-cycle debounced key pulses (start/stop, clear, lap) and turns them into a running MM:SS.cc time in packed BCD. It sits between the per-key debouncers and the seven-segment digit drivers. It divides CLOCK_50 down to a centisecond tick, counts BCD with wrap at 59:59.99, and supports a lap-freeze display mode.

## Interface
- TICK_DIV, 500000, CLOCK_50 cycles per centisecond tick (≥2); prescaler width is $clog2(TICK_DIV)
- CLOCK_50  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; sampled only on the rising edge of CLOCK_50
- start_stop  input  1  one-cycle pulse; toggles counting
- clear  input  1  one-cycle pulse; zero time, return to IDLE
- lap  input  1  one-cycle pulse; freeze/unfreeze displayed time
- disp_bcd  output  24  {min_t,min_o,sec_t,sec_o,cs_t,cs_o}, 4-bit BCD digits
- running  output  1  1 in RUN or LAP
- lap_active  output  1  1 in LAP
- wrap  output  1  one-cycle pulse on 59:59.99 -> 00:00.00

## Operation
- States: IDLE, RUN, PAUSE, LAP. Reset -> IDLE, time = 0, lap register = 0, prescaler = 0, wrap = 0.
- Input priority in one cycle: reset > clear > start_stop > lap. Lower-priority pulses in the same cycle are dropped, not queued.
- IDLE: start_stop -> RUN; lap and clear are no-ops.
- RUN: start_stop -> PAUSE; lap -> LAP, with the lap register loaded from the live time value at that edge (pre-increment value if a tick coincides).
- LAP: counting continues. lap -> RUN, display returns to live. start_stop -> PAUSE, display returns to live.
- PAUSE: start_stop -> RUN; lap is ignored.
- clear in any state: -> IDLE; time, lap register and prescaler are all zeroed.
- Prescaler counts only in RUN and LAP. At TICK_DIV-1 it returns to 0 and produces a tick; otherwise it increments. It holds its value in PAUSE, so a partial centisecond is preserved across pause/resume.
- A tick increments the BCD time as a cascade:
  - cs_o wraps 9->0 and carries to cs_t.
  - cs_t wraps 9->0 and carries to sec_o.
  - sec_o wraps 9->0 and carries to sec_t.
  - sec_t wraps 5->0 and carries to min_o.
  - min_o wraps 9->0 and carries to min_t.
  - min_t wraps 5->0.
  - Every digit is always within its legal range.
- disp_bcd is the lap register in LAP and the live time otherwise. It is a pure mux of registers.

## Timing
- All state, counter and output registers update on the rising edge of CLOCK_50. running, lap_active and disp_bcd follow the state/time registers with zero added latency.
- A start_stop pulse sampled at edge k sets running=1 after edge k. The prescaler advances from edge k+1 onward.
- From IDLE, the first cs increment is visible after edge k+TICK_DIV.
- The wrap pulse is registered: it is 1 for exactly the cycle after the edge where time becomes 00:00.00 by a tick. wrap is not asserted when time becomes 0 through clear.
- A clear coincident with a tick: clear wins, time = 0, wrap stays 0.
- Reset asserted mid-count: all outputs are 0 after that edge, regardless of the other inputs.

## Test plan
- Reset, then idle for 20 cycles with TICK_DIV=4 -> disp_bcd=0x000000, running=0, lap_active=0, wrap=0.
- TICK_DIV=4, start_stop pulse at edge 0 -> running=1 after edge 0; disp_bcd=0x000001 after edge 4, 0x000002 after edge 8. After 400 cycles disp_bcd=0x000100.
- TICK_DIV=4, start, run 2 cycles, pause for 50 cycles, resume -> next increment arrives 2 cycles after resume (prescaler held). disp_bcd is constant during the pause.
- TICK_DIV=2, preload time by running to 59:59.99 -> next tick gives disp_bcd=0x000000 and a 1-cycle wrap; running stays 1.
- In RUN at 0x000123, pulse lap -> lap_active=1, disp_bcd frozen at 0x000123 while the live time advances. Pulse lap again -> disp_bcd shows the live value. Pulse start_stop and lap in the same cycle -> PAUSE only.
- Pulse clear together with start_stop and with a tick edge -> IDLE, disp_bcd=0, wrap=0. Assert reset in LAP -> all outputs 0 next cycle.
